// File: rtl/p2s_stream.sv
// ---------------------------------------------------------------------------
// p2s_stream
//   Parametrised parallel-to-serial converter for the transmit chain.
//   Words arrive over a valid/ready handshake into a one-entry holding
//   register. They are then shifted out one bit per clock, with sof/eof
//   marking the first and last bit of each word. An optional header check
//   discards words whose top HDR_W bits differ from HDR_VAL, and counts the
//   discards.
//
// Ports
//   clk        : serial-rate clock
//   rst        : asynchronous active-high reset
//   din        : parallel input word (DATA_W bits)
//   din_valid  : din carries a word
//   din_ready  : holding register can take a word this cycle
//   dout       : serial bit (registered)
//   sig_valid  : dout carries a valid bit (registered)
//   sof        : high with the first bit of a word
//   eof        : high with the last bit of a word
//   busy       : shifter active or holding register occupied
//   drop_pulse : one-cycle pulse after a word is rejected by the header check
//   drop_cnt   : saturating count of rejected words (CNT_W bits)
// ---------------------------------------------------------------------------
module p2s_stream #(
  parameter int                DATA_W    = 16,
  parameter bit                MSB_FIRST = 1'b1,
  parameter bit                HDR_CHECK = 1'b1,
  parameter int                HDR_W     = 2,
  parameter logic [HDR_W-1:0]  HDR_VAL   = 2'b11,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              sig_valid,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int             CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic               hold_full;
  logic [DATA_W-1:0]  hold_data;
  logic [DATA_W-1:0]  shift_reg;
  logic [CW-1:0]      bit_cnt;

  logic               accept;
  logic               hdr_ok;
  logic               load;
  logic               first_bit;
  logic [DATA_W-1:0]  hold_rest;
  logic               next_bit;
  logic [DATA_W-1:0]  shift_rest;

  // The holding register takes a word whenever it is empty; din_ready is
  // forced low during reset so nothing is handed over while the block is
  // held in reset.
  assign din_ready = !hold_full && !rst;
  assign accept    = din_valid && din_ready;
  assign hdr_ok    = !HDR_CHECK || (din[DATA_W-1 -: HDR_W] == HDR_VAL);
  assign busy      = hold_full || (state == SHIFT);

  // A held word moves into the shifter either from IDLE or on the edge that
  // leaves the last bit of the previous word (counter wrapped back to 0),
  // which keeps back-to-back words gap-free.
  assign load = hold_full && ((state == IDLE) || (bit_cnt == '0));

  // Bit-order selection: the first bit presented and the remainder left in
  // the shift register, both for a fresh word and for a word mid-shift.
  always_comb begin
    first_bit  = 1'b0;
    hold_rest  = '0;
    next_bit   = 1'b0;
    shift_rest = '0;
    if (MSB_FIRST) begin
      first_bit  = hold_data[DATA_W-1];
      hold_rest  = hold_data << 1;
      next_bit   = shift_reg[DATA_W-1];
      shift_rest = shift_reg << 1;
    end else begin
      first_bit  = hold_data[0];
      hold_rest  = hold_data >> 1;
      next_bit   = shift_reg[0];
      shift_rest = shift_reg >> 1;
    end
  end

  // Input side: header filtering, holding register and drop statistics.
  // Accept only happens while the register is empty and load only while it
  // is full, so the two never compete for hold_full on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full  <= 1'b0;
      hold_data  <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (accept) begin
        if (hdr_ok) begin
          hold_full <= 1'b1;
          hold_data <= din;
        end else begin
          drop_pulse <= 1'b1;
          if (drop_cnt != {CNT_W{1'b1}}) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
          end
        end
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Shifter FSM with registered serial outputs. The load edge presents the
  // first bit and sets the counter to 1; in SHIFT the counter names the bit
  // being presented and wraps to 0 after the last one, so a counter of 0 in
  // SHIFT means the word has been fully sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      dout      <= 1'b0;
      sig_valid <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      sof <= 1'b0;
      eof <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state     <= SHIFT;
            dout      <= first_bit;
            shift_reg <= hold_rest;
            sig_valid <= 1'b1;
            sof       <= 1'b1;
            bit_cnt   <= CW'(1);
          end else begin
            dout      <= 1'b0;
            sig_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            if (load) begin
              dout      <= first_bit;
              shift_reg <= hold_rest;
              sig_valid <= 1'b1;
              sof       <= 1'b1;
              bit_cnt   <= CW'(1);
            end else begin
              state     <= IDLE;
              dout      <= 1'b0;
              sig_valid <= 1'b0;
            end
          end else begin
            dout      <= next_bit;
            shift_reg <= shift_rest;
            sig_valid <= 1'b1;
            eof       <= (bit_cnt == LAST_BIT);
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          dout      <= 1'b0;
          sig_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_stream.sv
// ---------------------------------------------------------------------------
// tb_p2s_stream
//   Directed testbench for p2s_stream. Three instances are used:
//   dut0 default parameters, dut1 LSB-first, dut2 with a 2-bit drop counter.
//   Captured serial streams are packed first-bit-first into the MSBs of the
//   captured vector and compared against hand-computed words and masks.
// ---------------------------------------------------------------------------
module tb_p2s_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] din0 = '0, din1 = '0, din2 = '0;
  logic        dv0 = 1'b0, dv1 = 1'b0, dv2 = 1'b0;
  logic        rdy0, rdy1, rdy2;
  logic        dout0, dout1, dout2;
  logic        sv0, sv1, sv2;
  logic        sof0, sof1, sof2;
  logic        eof0, eof1, eof2;
  logic        busy0, busy1, busy2;
  logic        dp0, dp1, dp2;
  logic [7:0]  dc0, dc1;
  logic [1:0]  dc2;

  int vec_count = 0;
  int err_count = 0;

  logic [31:0] cap_data, cap_sof, cap_eof, cap_val, cap_rdy;

  // Free-running serial clock, period 10.
  always #5 clk = ~clk;

  p2s_stream dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(dv0), .din_ready(rdy0),
    .dout(dout0), .sig_valid(sv0), .sof(sof0), .eof(eof0), .busy(busy0),
    .drop_pulse(dp0), .drop_cnt(dc0)
  );

  p2s_stream #(.MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(dv1), .din_ready(rdy1),
    .dout(dout1), .sig_valid(sv1), .sof(sof1), .eof(eof1), .busy(busy1),
    .drop_pulse(dp1), .drop_cnt(dc1)
  );

  p2s_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(dv2), .din_ready(rdy2),
    .dout(dout2), .sig_valid(sv2), .sof(sof2), .eof(eof2), .busy(busy2),
    .drop_pulse(dp2), .drop_cnt(dc2)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one word for one cycle to the selected instance. Returns 1 time
  // unit after the accepting edge with din_valid already dropped.
  task automatic applyStimulus(input int sel, input logic [15:0] word);
    @(posedge clk); #1;
    case (sel)
      0: begin din0 = word; dv0 = 1'b1; end
      1: begin din1 = word; dv1 = 1'b1; end
      default: begin din2 = word; dv2 = 1'b1; end
    endcase
    @(posedge clk); #1;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
  endtask

  // Samples n cycles of serial output 1 time unit after each edge, shifting
  // each sample into the LSB so the first bit ends up most significant.
  // dv0 is dropped after the sample with index drop_at.
  task automatic captureBits(input int sel, input int n, input int drop_at,
                             output logic [31:0] data, output logic [31:0] sofm,
                             output logic [31:0] eofm, output logic [31:0] valm,
                             output logic [31:0] rdym);
    logic d, s, e, v, r;
    data = '0; sofm = '0; eofm = '0; valm = '0; rdym = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == drop_at) dv0 = 1'b0;
      if (sel == 0) begin
        d = dout0; s = sof0; e = eof0; v = sv0; r = rdy0;
      end else begin
        d = dout1; s = sof1; e = eof1; v = sv1; r = rdy1;
      end
      data = {data[30:0], d};
      sofm = {sofm[30:0], s};
      eofm = {eofm[30:0], e};
      valm = {valm[30:0], v};
      rdym = {rdym[30:0], r};
    end
  endtask

  // Safety net in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state, sampled while reset is still asserted.
    #3;
    checkOutput("reset_outs0", {28'd0, dout0, sv0, sof0, eof0}, 32'h0);
    checkOutput("reset_misc0", {29'd0, busy0, dp0, rdy0}, 32'h0);
    checkOutput("reset_cnt0", {24'd0, dc0}, 32'h0);
    #20;
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", {31'd0, rdy0}, 32'h1);

    // Single word MSB first.
    $display("[TB] single word C35A");
    applyStimulus(0, 16'hC35A);
    checkOutput("c35a_latency", {30'd0, sv0, busy0}, 32'h1);
    captureBits(0, 16, -1, cap_data, cap_sof, cap_eof, cap_val, cap_rdy);
    checkOutput("c35a_data", cap_data, 32'h0000C35A);
    checkOutput("c35a_sof", cap_sof, 32'h00008000);
    checkOutput("c35a_eof", cap_eof, 32'h00000001);
    checkOutput("c35a_valid", cap_val, 32'h0000FFFF);
    @(posedge clk); #1;
    checkOutput("c35a_after", {30'd0, sv0, busy0}, 32'h0);

    // LSB-first instance.
    $display("[TB] LSB first C001");
    applyStimulus(1, 16'hC001);
    checkOutput("c001_latency", {31'd0, sv1}, 32'h0);
    captureBits(1, 16, -1, cap_data, cap_sof, cap_eof, cap_val, cap_rdy);
    checkOutput("c001_data", cap_data, 32'h00008003);
    checkOutput("c001_sof", cap_sof, 32'h00008000);
    checkOutput("c001_eof", cap_eof, 32'h00000001);
    checkOutput("c001_valid", cap_val, 32'h0000FFFF);

    // Back-to-back words with upstream always valid.
    $display("[TB] back-to-back FFFF, C000");
    @(posedge clk); #1;
    din0 = 16'hFFFF; dv0 = 1'b1;
    @(posedge clk); #1;
    din0 = 16'hC000;
    checkOutput("b2b_ready_full", {30'd0, rdy0, busy0}, 32'h1);
    captureBits(0, 32, 1, cap_data, cap_sof, cap_eof, cap_val, cap_rdy);
    checkOutput("b2b_data", cap_data, 32'hFFFFC000);
    checkOutput("b2b_sof", cap_sof, 32'h80008000);
    checkOutput("b2b_eof", cap_eof, 32'h00010001);
    checkOutput("b2b_valid", cap_val, 32'hFFFFFFFF);
    checkOutput("b2b_ready", {30'd0, cap_rdy[31:30]}, 32'h2);
    @(posedge clk); #1;
    checkOutput("b2b_after", {30'd0, sv0, busy0}, 32'h0);

    // Header reject followed by a good word.
    $display("[TB] header reject 4000 then C0F0");
    applyStimulus(0, 16'h4000);
    checkOutput("rej_pulse", {31'd0, dp0}, 32'h1);
    checkOutput("rej_cnt", {24'd0, dc0}, 32'h1);
    checkOutput("rej_idle", {30'd0, sv0, busy0}, 32'h0);
    @(posedge clk); #1;
    checkOutput("rej_pulse_end", {31'd0, dp0}, 32'h0);
    checkOutput("rej_no_out", {31'd0, sv0}, 32'h0);
    applyStimulus(0, 16'hC0F0);
    captureBits(0, 16, -1, cap_data, cap_sof, cap_eof, cap_val, cap_rdy);
    checkOutput("c0f0_data", cap_data, 32'h0000C0F0);
    checkOutput("c0f0_valid", cap_val, 32'h0000FFFF);
    checkOutput("c0f0_cnt", {24'd0, dc0}, 32'h1);

    // Saturating 2-bit drop counter.
    $display("[TB] drop counter saturation");
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(2, 16'h0000);
      checkOutput($sformatf("sat_pulse%0d", k), {31'd0, dp2}, 32'h1);
      checkOutput($sformatf("sat_cnt%0d", k), {30'd0, dc2},
                  (k < 3) ? k : 3);
    end
    checkOutput("sat_no_out", {30'd0, sv2, busy2}, 32'h0);

    // Asynchronous reset in the middle of a word.
    $display("[TB] reset mid-word");
    applyStimulus(0, 16'hC35A);
    captureBits(0, 7, -1, cap_data, cap_sof, cap_eof, cap_val, cap_rdy);
    checkOutput("mid_first7", cap_data, 32'h00000061);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_outs", {28'd0, dout0, sv0, eof0, busy0}, 32'h0);
    checkOutput("mid_rst_ready", {31'd0, rdy0}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("mid_hold%0d", k), {29'd0, sv0, eof0, busy0}, 32'h0);
    end
    rst = 1'b0;
    applyStimulus(0, 16'hFFC0);
    captureBits(0, 16, -1, cap_data, cap_sof, cap_eof, cap_val, cap_rdy);
    checkOutput("ffc0_data", cap_data, 32'h0000FFC0);
    checkOutput("ffc0_sof", cap_sof, 32'h00008000);
    checkOutput("ffc0_eof", cap_eof, 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/p2s_stream.md
Name: p2s_stream

Overview:
- Parametrised parallel-to-serial converter: successor to the fixed 16-bit serializer in the transmit chain.
- Accepts DATA_W-bit words over a valid/ready handshake into a one-entry holding register, then shifts them out one bit per clock with frame markers.
- Optional header check discards words whose top HDR_W bits do not match HDR_VAL; selectable bit order.
- Sits between the framing/encoding stage and the modulator, clocked on the serial-rate clock.

Parameters:
- DATA_W, 16, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- HDR_CHECK, 1, 1 = enable header filtering; 0 = accept every word.
- HDR_W, 2, header width in bits, taken from din[DATA_W-1 -: HDR_W]; must be 1..DATA_W.
- HDR_VAL, 2'b11, required header value.
- CNT_W, 8, width of drop_cnt.

Ports:
- clk, input, 1, serial-rate clock.
- rst, input, 1, asynchronous active-high reset.
- din, input, DATA_W, parallel word.
- din_valid, input, 1, din is valid.
- din_ready, output, 1, block can take a word this cycle.
- dout, output, 1, serial bit (registered).
- sig_valid, output, 1, dout carries a valid bit (registered).
- sof, output, 1, high with the first bit of a word.
- eof, output, 1, high with the last bit of a word.
- busy, output, 1, shifter active or holding register occupied.
- drop_pulse, output, 1, one-cycle pulse when a word is rejected by the header check.
- drop_cnt, output, CNT_W, saturating count of rejected words.

Behaviour:
Clock and reset:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- On reset: dout=0, sig_valid=0, sof=0, eof=0, drop_pulse=0, drop_cnt=0, holding register empty, shifter IDLE, bit counter 0.
- Reset asserted mid-word abandons the partial word: no further bits and no eof.
- din_ready is 0 while rst is high.

Input handshake:
- din_ready = !hold_full (combinational from state only; no dependence on din_valid).
- A word is accepted on a rising edge where din_valid && din_ready.
- Header check (HDR_CHECK=1): an accepted word whose header != HDR_VAL is discarded. The holding register is not written, drop_pulse=1 for the following cycle, and drop_cnt increments, saturating at all-ones.
- An accepted matching word (or any word when HDR_CHECK=0) is written to the holding register.

Shifter states:
- IDLE: sig_valid=0, dout=0, sof=0, eof=0.
- IDLE -> SHIFT on the edge where hold_full=1. That edge:
  - moves the word to the shift register and clears hold_full;
  - drives dout to the first bit with sig_valid=1 and sof=1;
  - sets the bit counter to 1.
- SHIFT: each edge presents the next bit in order; sof=0.
  - eof=1 when the last bit (counter DATA_W-1) is presented.
  - The counter wraps to 0 after the last bit.
- Leaving the last bit:
  - if hold_full=1, the next word loads on the same edge: sof=1, no idle gap;
  - otherwise SHIFT -> IDLE and sig_valid returns to 0.

Timing and edge cases:
- Latency: word accepted at edge N into an empty block -> first bit on dout after edge N+1.
- Simultaneous hold drain and new input: din_ready is evaluated before the edge, so the holding register refills one cycle after draining. Output still runs gap-free because DATA_W >= 2.
- Throughput: one word per DATA_W cycles sustained.
- busy = hold_full || state==SHIFT.
- din is not required to stay stable after acceptance.

Test Plan:
- Defaults; reset; then din=16'hC35A with din_valid for one cycle.
  -> Serial 1100_0011_0101_1010 on 16 consecutive cycles.
  -> sof on bit 1, eof on bit 16, sig_valid high exactly 16 cycles, first bit one cycle after accept.
- MSB_FIRST=0; din=16'hC001.
  -> Bit order 1,0,0,…,0,1,1.
- Back-to-back: 16'hFFFF then 16'hC000, upstream always valid.
  -> 32 contiguous valid bits.
  -> eof on cycle 16 and sof on cycle 17, with no sig_valid gap.
  -> din_ready low while the holding register is full.
- Header reject: din=16'h4000 then 16'hC0F0.
  -> First word produces drop_pulse for 1 cycle and drop_cnt=1, with no serial output.
  -> Second word serialises normally.
- Saturation: CNT_W=2; five bad-header words.
  -> drop_cnt sequence 1,2,3,3,3.
  -> drop_pulse on each rejected word.
- Reset mid-word: assert rst asynchronously after 7 bits of 16'hC35A.
  -> Immediately dout=0, sig_valid=0, eof never seen, busy=0.
  -> After release, a new word 16'hFFC0 serialises from its first bit.
